// File: rtl/ins_seq_ctrl.sv
// ins_seq_ctrl: multi-cycle instruction sequencer (fetch, decode, load, execute, store, write-back)
// Ports:
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   run, halt                  start sequencing from IDLE / stop after the instruction in WB retires
//   mem_req/we/addr/wdata      registered memory request, held until mem_ack
//   mem_ack, mem_rdata         one-cycle completion strobe and read data
//   ls_addr, st_op/addr/data   load address and store request from the execute datapath
//   ins, pc, ld_val            instruction register, current pc, latched load data
//   exec_op, retire, instret   execute strobe, retire strobe, retired-instruction count
//   fault                      high while in FAULT, cleared only by sys_rst
// Define INS_SEQ_TIMEOUT_EN to fault when an ack fails to arrive within TIMEOUT_CYC wait cycles.
module ins_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [3:0]  TIMEOUT_CYC = 4'd15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run,
  input  logic        halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] ls_addr,
  input  logic        st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] ld_val,
  output logic        exec_op,
  output logic        retire,
  output logic [31:0] instret,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, LOAD, EXEC, STORE, WB, FAULT} state_t;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  state_t state, nxt;
  logic [6:0] op;
  logic [31:0] pc_nxt;
  logic req_nxt, tmo;
  assign op      = ins[6:0];
  assign exec_op = state == EXEC;
  assign retire  = state == WB;
  assign fault   = state == FAULT;
`ifdef INS_SEQ_TIMEOUT_EN
  logic [3:0] tcnt;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) tcnt <= '0;
    else if (nxt != state) tcnt <= '0;
    else if (mem_req && !mem_ack) tcnt <= tcnt + 4'd1;
  end
  // this cycle is the last allowed wait cycle
  assign tmo = mem_req && !mem_ack && tcnt == TIMEOUT_CYC - 4'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = mem_ack ? DECODE : tmo ? FAULT : FETCH;
      DECODE:  nxt = op == OP_LOAD ? LOAD :
                     (op == OP_ALU || op == OP_ALUI || op == OP_STORE) ? EXEC : FAULT;
      LOAD:    nxt = mem_ack ? EXEC : tmo ? FAULT : LOAD;
      EXEC:    nxt = op == OP_STORE ? STORE : WB;
      // a store without st_op never raised mem_req, so it falls straight through
      STORE:   nxt = (!mem_req || mem_ack) ? WB : tmo ? FAULT : STORE;
      WB:      nxt = halt ? IDLE : FETCH;
      default: nxt = FAULT;
    endcase
  end
  assign pc_nxt  = nxt == IDLE ? RESET_PC : state == WB ? pc + 32'd4 : pc;
  // request outputs are registered so they are captured once on entry and stay stable until ack
  assign req_nxt = nxt == state ? mem_req : (nxt == FETCH || nxt == LOAD || (nxt == STORE && st_op));
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ins       <= '0;
      ld_val    <= '0;
      instret   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= nxt;
      pc      <= pc_nxt;
      mem_req <= req_nxt;
      if (state == FETCH && mem_ack) ins <= mem_rdata;
      if (state == LOAD && mem_ack) ld_val <= mem_rdata;
      if (state == WB) instret <= instret + 32'd1;
      if (nxt != state && nxt == FETCH) begin
        mem_we   <= 1'b0;
        mem_addr <= pc_nxt;
      end
      if (nxt != state && nxt == LOAD) begin
        mem_we   <= 1'b0;
        mem_addr <= ls_addr;
      end
      if (nxt != state && nxt == STORE && st_op) begin
        mem_we    <= 1'b1;
        mem_addr  <= st_addr;
        mem_wdata <= st_data;
      end
    end
  end
endmodule

// File: tb/tb_ins_seq_ctrl.sv
// tb_ins_seq_ctrl: scoreboard bench for ins_seq_ctrl
module tb_ins_seq_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic sys_clk = 1'b0, sys_rst = 1'b1, run = 1'b0, halt = 1'b0, mem_ack = 1'b0, st_op = 1'b0;
  logic [31:0] mem_rdata = '0, ls_addr = '0, st_addr = '0, st_data = '0;
  logic mem_req, mem_we, exec_op, retire, fault;
  logic [31:0] mem_addr, mem_wdata, ins, pc, ld_val, instret;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ret_t;
  req_t exp_req[$];
  ret_t exp_ret[$];
  ins_seq_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(4'd15)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ls_addr(ls_addr),
    .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .ins(ins), .pc(pc), .ld_val(ld_val), .exec_op(exec_op), .retire(retire),
    .instret(instret), .fault(fault)
  );
  always #5 sys_clk = ~sys_clk;
  logic prev_req = 1'b0;
  req_t prev_r = '0;
  always @(posedge sys_clk) begin
    req_t cur, e;
    ret_t r;
    #1;
    cur = req_t'{mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
    n_chk++;
    if (int'(exec_op) + int'(retire) + int'(mem_req) > 1) begin
      n_fail++;
      $display("FAIL exclusive: exec_op=%b retire=%b mem_req=%b, at most one required", exec_op, retire, mem_req);
    end
    if (!sys_rst && prev_req && !fault) begin
      n_chk++;
      if (mem_ack && mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL req_drop: mem_req=%b after ack, required 0", mem_req);
      end else if (!mem_ack && (mem_req !== 1'b1 || cur !== prev_r)) begin
        n_fail++;
        $display("FAIL req_hold: req=%b %h, required 1 %h", mem_req, cur, prev_r);
      end
    end
    if (mem_req && !prev_req) begin
      n_chk++;
      if (exp_req.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got %h, none expected", cur);
      end else begin
        e = exp_req.pop_front();
        if (cur !== e) begin
          n_fail++;
          $display("FAIL req_content: got %h expected %h", cur, e);
        end
      end
    end
    if (retire) begin
      n_chk++;
      if (exp_ret.size() == 0) begin
        n_fail++;
        $display("FAIL ret_unexpected: pc=%h ins=%h, none expected", pc, ins);
      end else begin
        r = exp_ret.pop_front();
        if ({pc, ins} !== r) begin
          n_fail++;
          $display("FAIL ret_content: got %h expected %h", {pc, ins}, r);
        end
      end
    end
    prev_req = mem_req;
    prev_r = cur;
  end
  task automatic do_reset();
    sys_rst = 1'b1; run = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({pc, ins, ld_val, instret} !== {RESET_PC, 96'h0}) begin
      n_fail++;
      $display("FAIL reset_regs: got %h expected %h", {pc, ins, ld_val, instret}, {RESET_PC, 96'h0});
    end
    n_chk++;
    if ({fault, mem_req, mem_we, mem_addr, mem_wdata, exec_op, retire} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 0", {fault, mem_req, mem_we, mem_addr, mem_wdata, exec_op, retire});
    end
    repeat (3) @(negedge sys_clk);
    n_chk++;
    if (mem_req !== 1'b0 || pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL idle_hold: mem_req=%b pc=%h, required 0 %h", mem_req, pc, RESET_PC);
    end
  endtask
  task automatic test_alu();
    logic [2:0] pat [5] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b100};
    do_reset();
    run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    exp_req.push_back(req_t'{1'b0, 32'h4, 32'h0});
    exp_ret.push_back(ret_t'{32'h0, 32'h0020_81B3});
    for (int c = 1; c <= 5; c++) begin
      @(negedge sys_clk);
      mem_ack = 1'b0;
      n_chk++;
      if ({mem_req, exec_op, retire} !== pat[c-1]) begin
        n_fail++;
        $display("FAIL alu_cycle%0d: req/exec/ret=%b expected %b", c, {mem_req, exec_op, retire}, pat[c-1]);
      end
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0020_81B3; end
    end
    n_chk++;
    if ({pc, instret, ins} !== {32'h4, 32'h1, 32'h0020_81B3}) begin
      n_fail++;
      $display("FAIL alu_state: pc/instret/ins=%h expected %h", {pc, instret, ins}, {32'h4, 32'h1, 32'h0020_81B3});
    end
    do_reset();
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL alu_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  task automatic test_load();
    logic [2:0] pat [9] = '{3'b100, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
    int held = 0;
    do_reset();
    ls_addr = 32'h100; halt = 1'b1; run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    exp_req.push_back(req_t'{1'b0, 32'h100, 32'h0});
    exp_ret.push_back(ret_t'{32'h0, 32'h0000_A103});
    for (int c = 1; c <= 9; c++) begin
      @(negedge sys_clk);
      run = 1'b0; mem_ack = 1'b0;
      n_chk++;
      if ({mem_req, exec_op, retire} !== pat[c-1]) begin
        n_fail++;
        $display("FAIL load_cycle%0d: req/exec/ret=%b expected %b", c, {mem_req, exec_op, retire}, pat[c-1]);
      end
      if (mem_req && mem_addr == 32'h100) held++;
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0000_A103; end
      if (c == 6) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      if (c == 7) begin
        n_chk++;
        if (ld_val !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL load_val: ld_val=%h expected deadbeef", ld_val);
        end
      end
    end
    n_chk++;
    if (held != 4) begin
      n_fail++;
      $display("FAIL load_addr_hold: %0d cycles at 0x100, expected 4", held);
    end
    n_chk++;
    if (instret !== 32'h1 || pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL load_halt: instret=%h pc=%h expected 1 %h", instret, pc, RESET_PC);
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL load_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  task automatic test_store(input logic op);
    logic [2:0] pat [6] = '{3'b100, 3'b000, 3'b010, {op, 2'b00}, 3'b001, 3'b000};
    do_reset();
    st_op = op; st_addr = 32'h200; st_data = 32'h1234; halt = 1'b1; run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    if (op) exp_req.push_back(req_t'{1'b1, 32'h200, 32'h1234});
    exp_ret.push_back(ret_t'{32'h0, 32'h0020_A023});
    for (int c = 1; c <= 6; c++) begin
      @(negedge sys_clk);
      run = 1'b0; mem_ack = 1'b0;
      n_chk++;
      if ({mem_req, exec_op, retire} !== pat[c-1]) begin
        n_fail++;
        $display("FAIL store%0d_cycle%0d: req/exec/ret=%b expected %b", op, c, {mem_req, exec_op, retire}, pat[c-1]);
      end
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0020_A023; end
      if (c == 4 && op) begin
        n_chk++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'h1234}) begin
          n_fail++;
          $display("FAIL store_req: we/addr/wdata=%h expected %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h200, 32'h1234});
        end
        mem_ack = 1'b1;
      end
    end
    n_chk++;
    if (instret !== 32'h1) begin
      n_fail++;
      $display("FAIL store%0d_instret: %h expected 1", op, instret);
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL store_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
    st_op = 1'b0;
  endtask
  task automatic test_illegal();
    do_reset();
    run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      mem_ack = 1'b0;
      n_chk++;
      if ({fault, mem_req, exec_op, retire} !== {c >= 3, c == 1, 2'b00}) begin
        n_fail++;
        $display("FAIL illegal_cycle%0d: fault/req/exec/ret=%b expected %b", c, {fault, mem_req, exec_op, retire}, {c >= 3, c == 1, 2'b00});
      end
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0000_006F; end
    end
    do_reset();
    n_chk++;
    if ({fault, mem_req, pc, instret, ins} !== {2'b00, RESET_PC, 64'h0}) begin
      n_fail++;
      $display("FAIL fault_clear: got %h expected %h", {fault, mem_req, pc, instret, ins}, {2'b00, RESET_PC, 64'h0});
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  task automatic test_halt_wrap();
    logic [2:0] pat [7] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    @(negedge sys_clk);
    release dut.instret;
    run = 1'b1; halt = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    exp_ret.push_back(ret_t'{32'h0, 32'h0020_81B3});
    for (int c = 1; c <= 7; c++) begin
      @(negedge sys_clk);
      run = 1'b0; mem_ack = 1'b0;
      n_chk++;
      if ({mem_req, exec_op, retire} !== pat[c-1]) begin
        n_fail++;
        $display("FAIL halt_cycle%0d: req/exec/ret=%b expected %b", c, {mem_req, exec_op, retire}, pat[c-1]);
      end
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0020_81B3; end
    end
    n_chk++;
    if (instret !== 32'h0 || pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL wrap: instret=%h pc=%h expected 0 %h", instret, pc, RESET_PC);
    end
    do_reset();
    run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    repeat (4) begin
      @(negedge sys_clk);
      run = 1'b0;
    end
    sys_rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0020_81B3;
    @(negedge sys_clk);
    sys_rst = 1'b0; mem_ack = 1'b0;
    n_chk++;
    if ({mem_req, retire, ins, pc} !== {2'b00, 32'h0, RESET_PC}) begin
      n_fail++;
      $display("FAIL rst_in_fetch: req/ret/ins/pc=%h expected %h", {mem_req, retire, ins, pc}, {2'b00, 32'h0, RESET_PC});
    end
    repeat (4) @(negedge sys_clk);
    n_chk++;
    if (instret !== 32'h0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abandon: instret=%h req=%b expected 0 0", instret, mem_req);
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL halt_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] pat [9] = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b010, 3'b001, 3'b000};
    int r1 = 0, r2 = 0;
    do_reset();
    run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
    exp_req.push_back(req_t'{1'b0, 32'h4, 32'h0});
    exp_ret.push_back(ret_t'{32'h0, 32'h0020_81B3});
    exp_ret.push_back(ret_t'{32'h4, 32'h0010_8093});
    for (int c = 1; c <= 9; c++) begin
      @(negedge sys_clk);
      run = 1'b0; mem_ack = 1'b0;
      n_chk++;
      if ({mem_req, exec_op, retire} !== pat[c-1]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: req/exec/ret=%b expected %b", c, {mem_req, exec_op, retire}, pat[c-1]);
      end
      if (retire) begin
        if (r1 == 0) r1 = c;
        else r2 = c;
      end
      if (c == 1) begin mem_ack = 1'b1; mem_rdata = 32'h0020_81B3; end
      if (c == 5) begin mem_ack = 1'b1; mem_rdata = 32'h0010_8093; halt = 1'b1; end
    end
    n_chk++;
    if (r2 - r1 != 4 || r1 == 0) begin
      n_fail++;
      $display("FAIL b2b_gap: retires at %0d and %0d, expected 4 apart", r1, r2);
    end
    n_chk++;
    if (instret !== 32'h2 || pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL b2b_state: instret=%h pc=%h expected 2 %h", instret, pc, RESET_PC);
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  task automatic test_timeout();
`ifdef INS_SEQ_TIMEOUT_EN
    int reqs = 0;
    bit got = 1'b0;
`else
    int bad = 0;
`endif
    do_reset();
    run = 1'b1;
    exp_req.push_back(req_t'{1'b0, 32'h0, 32'h0});
`ifdef INS_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge sys_clk);
      run = 1'b0;
      if (fault) got = 1'b1;
      else if (mem_req) reqs++;
    end
    n_chk++;
    if (!got || reqs != 15) begin
      n_fail++;
      $display("FAIL timeout: fault=%b after %0d request cycles, expected 1 after 15", got, reqs);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge sys_clk);
      run = 1'b0;
      if (mem_req !== 1'b1 || fault !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_timeout: %0d cycles without req or with fault, expected 0", bad);
    end
`endif
    do_reset();
    n_chk++;
    if (fault !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: fault=%b req=%b expected 0 0", fault, mem_req);
    end
    n_chk++;
    if (exp_req.size() + exp_ret.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_drain: %0d entries left, required 0", exp_req.size() + exp_ret.size());
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store(1'b1);
    test_store(1'b0);
    test_illegal();
    test_halt_wrap();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ins_seq_ctrl.md
INS_SEQ_CTRL -- requirements
Module: ins_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: program counter value loaded at reset and on entry to IDLE.
REQ-002 Parameter TIMEOUT_CYC, default 4'd15: memory-ack wait limit in cycles; used only when INS_SEQ_TIMEOUT_EN is defined.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 sys_clk  input  1  sole clock; all state updates on posedge.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; starts sequencing from IDLE.
REQ-007 halt  input  1  level; sampled in WB, returns to IDLE after the current instruction retires.
REQ-008 mem_req  output  1  memory request, held high until mem_ack.
REQ-009 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  output  32  request address; stable while mem_req.
REQ-011 mem_wdata  output  32  write data; stable while mem_req && mem_we.
REQ-012 mem_ack  input  1  one-cycle completion strobe; ignored while mem_req=0.
REQ-013 mem_rdata  input  32  read data; valid in the cycle mem_ack=1.
REQ-014 ls_addr  input  32  load address from the execute datapath (rs1+imm).
REQ-015 st_op / st_addr / st_data  input  1/32/32  store request from the execute datapath, valid in STORE.
REQ-016 ins  output  32  instruction register.
REQ-017 pc  output  32  address of the current instruction.
REQ-018 ld_val  output  32  latched load data for the execute datapath.
REQ-019 exec_op  output  1  one-cycle execute strobe.
REQ-020 retire  output  1  one-cycle strobe per retired instruction.
REQ-021 instret  output  32  count of retired instructions.
REQ-022 fault  output  1  sticky; high in FAULT.

Function
REQ-023 States: IDLE, FETCH, DECODE, LOAD, EXEC, STORE, WB, FAULT.
REQ-024 IDLE: pc is held at RESET_PC; when run=1, next state is FETCH.
REQ-025 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, ins<=mem_rdata and next state is DECODE.
REQ-026 DECODE (one cycle), dispatch on ins[6:0]:
  - 0000011 -> LOAD
  - 0110011, 0010011, 0100011 -> EXEC
  - any other opcode -> FAULT
REQ-027 LOAD: mem_req=1, mem_we=0, mem_addr=ls_addr; on mem_ack, ld_val<=mem_rdata and next state is EXEC.
REQ-028 EXEC (one cycle): exec_op=1.
  - ins[6:0]=0100011 -> STORE
  - otherwise -> WB
REQ-029 STORE with st_op=1: mem_req=1, mem_we=1, mem_addr=st_addr, mem_wdata=st_data; on mem_ack, next state is WB.
REQ-030 STORE with st_op=0: no request issued; next state is WB.
REQ-031 WB (one cycle): retire=1, pc<=pc+4 (mod 2^32), instret<=instret+1 (wraps 32'hFFFF_FFFF -> 0).
  - halt=1 -> IDLE
  - halt=0 -> FETCH
REQ-032 mem_addr, mem_we and mem_wdata SHALL NOT change while mem_req=1 and mem_ack=0.
REQ-033 mem_req SHALL drop in the cycle after mem_ack.
REQ-034 Minimum instruction latencies, with mem_ack in the first request cycle:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB)
  - load or store: 5 cycles
  - retire pulses for back-to-back ALU instructions are 4 cycles apart.
REQ-035 run deasserted mid-instruction has no effect; only halt sampled in WB stops sequencing.
REQ-036 FAULT: fault=1, mem_req=0, exec_op=0, retire=0; exit only by sys_rst.
REQ-037 exec_op, retire and mem_req SHALL never be high in the same cycle.

Reset
REQ-038 When sys_rst=1 at posedge, the block SHALL enter IDLE and set pc=RESET_PC, ins=0, ld_val=0, instret=0, fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, exec_op=0, retire=0, and timeout counter=0.
REQ-039 Reset SHALL take priority over every event, including a mem_ack in the same cycle; a pending request is abandoned without retire.

Configuration
REQ-040 Macro INS_SEQ_TIMEOUT_EN, when defined: a 4-bit counter clears on entry to FETCH, LOAD or STORE, increments each cycle mem_req=1 and mem_ack=0, and forces FAULT when it reaches TIMEOUT_CYC without an ack.
REQ-041 When INS_SEQ_TIMEOUT_EN is undefined, the block SHALL wait for mem_ack indefinitely and SHALL contain no counter.

Verification
REQ-042 ALU instruction: reset, run=1, memory returns 32'h0020_81B3 (add) with ack in 1 cycle -> exec_op at cycle 3, retire at cycle 4, pc=4, instret=1.
REQ-043 Load instruction: fetch 32'h0000_A103 (lw), ls_addr=32'h100, read ack after 3 wait cycles with 32'hDEAD_BEEF -> mem_addr=32'h100 held stable for 4 cycles, ld_val=32'hDEAD_BEEF, then exec_op, then retire.
REQ-044 Store instruction: fetch 32'h0020_A023 (sw), st_op=1, st_addr=32'h200, st_data=32'h1234 -> write request with mem_we=1, mem_addr=32'h200, mem_wdata=32'h1234 after exec_op; retire follows the ack.
REQ-045 Illegal opcode: fetch 32'h0000_006F -> FAULT entered after DECODE; fault=1, no further mem_req; sys_rst clears fault and returns to IDLE.
REQ-046 halt and wrap: instret preset to 32'hFFFF_FFFF, halt=1 during an ALU instruction -> instret=0 and state IDLE after WB; separately, sys_rst asserted during a FETCH wait -> mem_req=0 next cycle.
REQ-047 Timeout: with INS_SEQ_TIMEOUT_EN defined, mem_ack held 0 -> fault=1 after 15 wait cycles; with the macro undefined, mem_req remains high for 100 cycles with no fault.
